vram_arbiter: RTL
=================

# vram_arbiter

Parametrised VRAM access arbiter replacing the direct Renderer/MPU mux in front of the external VRAM bus. Accepts up to NUM_CLIENTS independent request/grant ports (Renderer, MPU, later blitter/DMA), picks one per transaction by round-robin, and drives the active-low VRAM strobes for a configurable number of access cycles. Read data is registered and returned with a one-cycle grant pulse.

## Interface
- NUM_CLIENTS, 2, number of requesters (1..8); client i occupies slice i of every packed bus
- ADDR_WIDTH, 16, VRAM address width
- DATA_WIDTH, 16, VRAM data width; multiple of 8; BE_WIDTH = DATA_WIDTH/8
- ACCESS_CYCLES, 2, cycles _vram_en is held low per transaction (>=1)
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_CLIENTS  per-client request, level, held until grant
- req_wr  input  NUM_CLIENTS  1 = write, 0 = read
- req_be  input  NUM_CLIENTS*BE_WIDTH  byte enables, active high
- req_addr  input  NUM_CLIENTS*ADDR_WIDTH  packed addresses
- req_wdata  input  NUM_CLIENTS*DATA_WIDTH  packed write data
- grant  output  NUM_CLIENTS  one-hot, one-cycle pulse at transaction completion
- rdata  output  DATA_WIDTH  read data of last completed read
- busy  output  1  high while not IDLE
- _vram_en, _vram_rd, _vram_wr  output  1 each  active-low strobes
- _vram_be  output  BE_WIDTH  active-low byte enables
- vram_addr  output  ADDR_WIDTH  VRAM address
- vram_data  inout  DATA_WIDTH  driven only during write access, else high-Z

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req bit set, select winner (see arbitration), latch its wr/be/addr/wdata into command registers, load cycle counter with ACCESS_CYCLES-1, go ACCESS. No request: stay IDLE.
- ACCESS: _vram_en=0; _vram_rd=0 for read or _vram_wr=0 for write; _vram_be=~latched be; vram_addr=latched addr; vram_data=latched wdata for writes. Counter decrements each cycle; at 0, reads capture vram_data into rdata; go DONE.
- DONE: all strobes deasserted, vram_data high-Z; grant[winner]=1 for this cycle only; round-robin pointer := winner; go IDLE. No arbitration in DONE.
- Arbitration: search starts at (pointer+1) mod NUM_CLIENTS, lowest-index-first wrap-around; first set req wins. Pointer resets to NUM_CLIENTS-1 so client 0 wins first.
- Client rule: hold req and command stable until grant sampled high; drop or replace req on that edge. Req dropped before grant is protocol violation; transaction already latched still completes and grants.
- Writes leave rdata unchanged.
- Reset (any time, including mid-ACCESS): immediately IDLE, _vram_en/_vram_rd/_vram_wr=1, _vram_be all 1, vram_addr=0, vram_data high-Z, grant=0, rdata=0, busy=0, pointer=NUM_CLIENTS-1, counter=0. Aborted transaction is not granted.

## Timing
- Transaction length ACCESS_CYCLES+2 cycles: IDLE decision (1), ACCESS (ACCESS_CYCLES), DONE (1).
- Strobes are registered outputs: first low in the cycle after the IDLE decision.
- Request seen in IDLE at edge T -> _vram_en low from T+1 to T+ACCESS_CYCLES -> grant high in cycle T+ACCESS_CYCLES+1.
- rdata valid in the grant cycle and stable until the next read's DONE.
- Simultaneous requests: one winner per transaction; others wait; with all clients requesting continuously each is served once per NUM_CLIENTS transactions.

## Configuration
- VRAM_ARB_RENDER_PRIORITY_EN: when defined, client 0 (Renderer) wins any IDLE arbitration in which req[0]=1, regardless of pointer; remaining clients arbitrate round-robin among themselves when req[0]=0. Undefined: pure round-robin across all clients as above.

## Test plan
- Reset, single read: NUM_CLIENTS=2, ACCESS_CYCLES=2, client 1 reads addr 0x1234, model returns 0xBEEF -> _vram_en/_vram_rd low exactly 2 cycles, vram_addr=0x1234, grant=2'b10 pulse 1 cycle later, rdata=0xBEEF.
- Byte write: client 0 writes 0xA55A to 0x0010, be=2'b01 -> _vram_wr low 2 cycles, _vram_be=2'b10, vram_data=0xA55A only during ACCESS, high-Z otherwise, rdata unchanged.
- Fairness: NUM_CLIENTS=4, all req held continuously -> grant order 0,1,2,3,0,1,... one transaction every 4 cycles.
- Priority macro: with VRAM_ARB_RENDER_PRIORITY_EN, clients 0 and 1 always requesting -> client 0 granted every transaction; without macro -> alternating 0,1.
- Reset mid-ACCESS: assert reset during 1st ACCESS cycle -> strobes high and vram_data high-Z same cycle, no grant, after release next req served normally starting with client 0.
- ACCESS_CYCLES=1 boundary: back-to-back reads from one client -> _vram_en low 1 cycle, grant every 3 cycles, rdata updated each grant.

Source files
------------

// File: rtl/vram_arbiter_if.sv
`timescale 1ns/1ps
// Client-side and VRAM-strobe bundle for vram_arbiter. The shared vram_data bus is a
// separate inout port on the arbiter so the tristate stays at module level.
interface vram_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Handshake: a client raises req[i] with its command fields stable and holds them
    // until it samples grant[i] high; on that edge it may drop req or present a new one.
    logic [NUM_CLIENTS-1:0]            req;
    logic [NUM_CLIENTS-1:0]            req_wr;
    logic [NUM_CLIENTS*BE_WIDTH-1:0]   req_be;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CLIENTS-1:0]            grant;
    logic [DATA_WIDTH-1:0]             rdata;
    logic                              busy;
    logic                              _vram_en;
    logic                              _vram_rd;
    logic                              _vram_wr;
    logic [BE_WIDTH-1:0]               _vram_be;
    logic [ADDR_WIDTH-1:0]             vram_addr;
    logic [1:0]                        fsm_state;

    modport slave (
        input  req, req_wr, req_be, req_addr, req_wdata,
        output grant, rdata, busy, _vram_en, _vram_rd, _vram_wr, _vram_be, vram_addr,
        output fsm_state
    );

    modport master (
        output req, req_wr, req_be, req_addr, req_wdata,
        input  grant, rdata, busy, _vram_en, _vram_rd, _vram_wr, _vram_be, vram_addr,
        input  fsm_state
    );
endinterface

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// Round-robin VRAM arbiter: one client per transaction, active-low strobes for ACCESS_CYCLES.
// Optional build macro VRAM_ARB_RENDER_PRIORITY_EN gives client 0 absolute priority.
module vram_arbiter #(
    parameter int NUM_CLIENTS   = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    vram_arbiter_if.slave         bus,
    inout  wire [DATA_WIDTH-1:0]  vram_data
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           ptr_q;
    logic [PW-1:0]           win_q;
    logic [CW-1:0]           cnt_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    drive_q;
    logic                    en_n_q;
    logic                    rd_n_q;
    logic                    wr_n_q;
    logic [BE_WIDTH-1:0]     be_n_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [NUM_CLIENTS-1:0]  grant_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    found_d;
    logic [PW-1:0]           win_d;
    logic [PW-1:0]           cand;

    // Wrap-around search starting just after the last winner.
    always_comb begin
        found_d = 1'b0;
        win_d   = ptr_q;
        cand    = ptr_q;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_CLIENTS);
            if (!found_d && bus.req[cand]) begin
                found_d = 1'b1;
                win_d   = cand;
            end
        end
`ifdef VRAM_ARB_RENDER_PRIORITY_EN
        if (bus.req[0]) begin
            found_d = 1'b1;
            win_d   = '0;
        end
`else
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUM_CLIENTS - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            drive_q <= 1'b0;
            en_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            be_n_q  <= '1;
            addr_q  <= '0;
            grant_q <= '0;
            rdata_q <= '0;
        end else begin
            grant_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        win_q   <= win_d;
                        wr_q    <= bus.req_wr[win_d];
                        wdata_q <= bus.req_wdata[int'(win_d)*DATA_WIDTH +: DATA_WIDTH];
                        addr_q  <= bus.req_addr[int'(win_d)*ADDR_WIDTH +: ADDR_WIDTH];
                        be_n_q  <= ~bus.req_be[int'(win_d)*BE_WIDTH +: BE_WIDTH];
                        cnt_q   <= CW'(ACCESS_CYCLES - 1);
                        en_n_q  <= 1'b0;
                        rd_n_q  <= bus.req_wr[win_d];
                        wr_n_q  <= ~bus.req_wr[win_d];
                        drive_q <= bus.req_wr[win_d];
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!wr_q) rdata_q <= vram_data;
                        en_n_q         <= 1'b1;
                        rd_n_q         <= 1'b1;
                        wr_n_q         <= 1'b1;
                        be_n_q         <= '1;
                        drive_q        <= 1'b0;
                        grant_q[win_q] <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    ptr_q   <= win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vram_data     = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign bus.grant     = grant_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus._vram_en  = en_n_q;
    assign bus._vram_rd  = rd_n_q;
    assign bus._vram_wr  = wr_n_q;
    assign bus._vram_be  = be_n_q;
    assign bus.vram_addr = addr_q;
    assign bus.fsm_state = state_q;
endmodule
